// File: rtl/red_pkg.sv
// Shared constants, elaboration helpers and the per-stage control record for the
// Barrett / Montgomery reducers.
package red_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int DILITHIUM_Q   = 8380417;
  localparam int RED_TAG_MAX_W = 16;

  // floor(2^k / q); k is limited to 63 so the shift stays inside 64 bits
  function automatic longint unsigned barrett_mu(input longint unsigned q, input int k);
    return (64'd1 << k) / q;
  endfunction

  function automatic int red_w(input longint unsigned q);
    return $clog2(q);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [RED_TAG_MAX_W-1:0] tag;
    logic                     flag;
  } stage_ctrl_t;

endpackage

// File: rtl/red_barrett_corr.sv
// Final correction step: brings a value known to lie in [0, 3Q) into [0, Q-1]
// with at most two conditional subtractions of Q.
module red_barrett_corr
  import red_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int W = red_w(Q)
) (
  input  logic [W+1:0] value,
  output logic [W-1:0] result
);

  localparam logic [W+1:0] Q_R = (W+2)'(Q);

  logic [W+1:0] once;
  logic [W+1:0] twice;
  logic [1:0]   unused_hi;

  always_comb begin
    once  = (value >= Q_R) ? value - Q_R : value;
    twice = (once >= Q_R) ? once - Q_R : once;
  end

  // After two corrections the top bits are always zero
  assign result    = twice[W-1:0];
  assign unused_hi = twice[W+1:W];

endmodule

// File: rtl/red_barrett_pipe.sv
// Three-stage pipelined Barrett reduction x mod Q with valid/ready flow control,
// a pass-through tag and an out-of-range (x >= Q*Q) flag.
module red_barrett_pipe
  import red_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int W     = red_w(Q),
  parameter int IN_W  = 2*W,
  parameter int K     = IN_W,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  product_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W-1:0]     result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             range_err_o
);

  // Q > 2^(W-1) bounds MU below 2^(K-W+1)
  localparam int MU_W = K - W + 1;
  localparam int M_W  = IN_W + MU_W;
  localparam int T_W  = M_W - K;

  localparam logic [MU_W-1:0] MU  = MU_W'(barrett_mu(64'(Q), K));
  localparam logic [63:0]     QSQ = 64'(Q) * 64'(Q);
  localparam logic [W+1:0]    Q_R = (W+2)'(Q);

  generate
    if (K < IN_W || K > 63 || IN_W > 64 || TAG_W > RED_TAG_MAX_W) begin : g_bad_params
      $error("red_barrett_pipe: need IN_W <= K <= 63, IN_W <= 64, TAG_W <= RED_TAG_MAX_W");
    end
  endgenerate

  stage_ctrl_t s1_ctrl;
  stage_ctrl_t s2_ctrl;
  stage_ctrl_t s3_ctrl;

  logic [W+1:0]  s1_x;
  logic [M_W-1:0] s1_m;
  logic [W+1:0]  s2_r;
  logic [W-1:0]  s3_result;

  logic          load1;
  logic          load2;
  logic          load3;
  logic          in_flag;
  logic [T_W-1:0] t;
  logic [W+1:0]  tq;
  logic [W+1:0]  r;
  logic [W-1:0]  corr;
  logic          unused_bits;

  // A stage may load when it is empty or its content moves on this edge
  assign load3   = !s3_ctrl.valid || ready_i;
  assign load2   = !s2_ctrl.valid || load3;
  assign load1   = !s1_ctrl.valid || load2;
  assign ready_o = load1;

  assign in_flag = 64'(product_i) >= QSQ;

  // Only the low W+2 bits matter: the true remainder is below 3Q < 2^(W+2)
  assign t  = s1_m[M_W-1:K];
  assign tq = (W+2)'(t) * Q_R;
  assign r  = s1_x - tq;

  red_barrett_corr #(
    .Q (Q),
    .W (W)
  ) u_corr (
    .value  (s2_r),
    .result (corr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_ctrl   <= '0;
      s2_ctrl   <= '0;
      s3_ctrl   <= '0;
      s3_result <= '0;
    end else begin
      if (load1) begin
        if (valid_i) begin
          s1_ctrl <= '{valid: 1'b1, tag: RED_TAG_MAX_W'(tag_i), flag: in_flag};
        end else begin
          s1_ctrl.valid <= 1'b0;
        end
      end
      if (load2) begin
        if (s1_ctrl.valid) begin
          s2_ctrl <= s1_ctrl;
        end else begin
          s2_ctrl.valid <= 1'b0;
        end
      end
      if (load3) begin
        if (s2_ctrl.valid) begin
          s3_ctrl   <= s2_ctrl;
          s3_result <= corr;
        end else begin
          s3_ctrl.valid <= 1'b0;
        end
      end
    end
  end

  // Datapath registers are qualified by the stage valids, so they need no reset
  always_ff @(posedge clk_i) begin
    if (load1 && valid_i) begin
      s1_x <= (W+2)'(product_i);
      s1_m <= M_W'(product_i) * M_W'(MU);
    end
    if (load2 && s1_ctrl.valid) begin
      s2_r <= r;
    end
  end

  assign valid_o     = s3_ctrl.valid;
  assign result_o    = s3_result;
  assign tag_o       = s3_ctrl.tag[TAG_W-1:0];
  assign range_err_o = s3_ctrl.flag;

  assign unused_bits = ^{s1_m[K-1:0], s3_ctrl.tag};

endmodule
